// File: rtl/tangram_pkg.sv
// Shared constants, state type and helpers for the tangram input controller.
package tangram_pkg;

  localparam int NUM_PIECES_DEF = 7;
  localparam int H_MIN_DEF      = 215;
  localparam int V_MIN_DEF      = 26;

  localparam int DIR_UP    = 0;
  localparam int DIR_DOWN  = 1;
  localparam int DIR_LEFT  = 2;
  localparam int DIR_RIGHT = 3;

  typedef enum logic {
    IDLE = 1'b0,
    MOVE = 1'b1
  } move_state_t;

  // Highest-priority held direction: up > down > left > right.
  function automatic logic [3:0] dir_onehot(input logic [3:0] m);
    logic [3:0] r;
    r = '0;
    if (m[DIR_UP])         r[DIR_UP]    = 1'b1;
    else if (m[DIR_DOWN])  r[DIR_DOWN]  = 1'b1;
    else if (m[DIR_LEFT])  r[DIR_LEFT]  = 1'b1;
    else if (m[DIR_RIGHT]) r[DIR_RIGHT] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer; EDGE selects a rising-edge pulse instead of the level.
module sync_edge #(
  parameter int W    = 1,
  parameter bit EDGE = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] sync_p0, sync_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
    end
  end

  if (EDGE) begin : g_edge
    logic [W-1:0] sync_p2;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_p2 <= '0;
      else        sync_p2 <= sync_p1;
    end
    assign q = sync_p1 & ~sync_p2;
  end else begin : g_level
    assign q = sync_p1;
  end

endmodule

// File: rtl/piece_controller.sv
// Shared button controller: piece selection plus raster-aligned, rate-limited
// move and rotate step pulses for the tangram shape blocks.
module piece_controller
  import tangram_pkg::*;
#(
  parameter int NUM_PIECES = NUM_PIECES_DEF,
  parameter int H_MIN      = H_MIN_DEF,
  parameter int V_MIN      = V_MIN_DEF,
  parameter int MOVE_DIV   = 507,
  parameter int ROT_FRAMES = 60
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [10:0]           hc,
  input  logic [10:0]           vc,
  input  logic                  enable,
  input  logic                  sel_btn,
  input  logic [3:0]            move_in,
  input  logic                  rotate_in,
  output logic [2:0]            sel_idx,
  output logic [NUM_PIECES-1:0] piece_en,
  output logic [3:0]            move_step,
  output logic                  rotate_step,
  output logic                  busy
);

  localparam int LCW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam int FCW = (ROT_FRAMES > 1) ? $clog2(ROT_FRAMES) : 1;
  localparam logic [LCW-1:0] LINE_LAST  = LCW'(MOVE_DIV - 1);
  localparam logic [FCW-1:0] FRAME_LAST = FCW'(ROT_FRAMES - 1);
  localparam logic [2:0]     SEL_LAST   = 3'(NUM_PIECES - 1);

  logic       sel_rise;
  logic [3:0] mv;
  logic       rot;

  sync_edge #(.W(1), .EDGE(1'b1)) u_sync_sel (
    .clk(clk), .rst_n(rst_n), .d(sel_btn), .q(sel_rise)
  );

  sync_edge #(.W(5), .EDGE(1'b0)) u_sync_lvl (
    .clk(clk), .rst_n(rst_n), .d({rotate_in, move_in}), .q({rot, mv})
  );

  logic line_start, frame_start;
  assign line_start  = (hc == 11'(H_MIN));
  assign frame_start = line_start && (vc == 11'(V_MIN));

  move_state_t    state, state_d;
  logic [LCW-1:0] line_cnt, line_cnt_d;
  logic [3:0]     step_d;

  always_comb begin
    state_d    = state;
    line_cnt_d = line_cnt;
    step_d     = '0;
    case (state)
      IDLE: begin
        if (enable && (|mv)) begin
          state_d    = MOVE;
          line_cnt_d = '0;
        end
      end
      MOVE: begin
        if (!enable || (mv == 4'd0)) begin
          state_d    = IDLE;
          line_cnt_d = '0;
        end else if (line_start) begin
          if (line_cnt == LINE_LAST) begin
            line_cnt_d = '0;
            step_d     = dir_onehot(mv);
          end else begin
            line_cnt_d = line_cnt + LCW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      line_cnt  <= '0;
      move_step <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      line_cnt  <= line_cnt_d;
      move_step <= step_d;
      busy      <= (state_d == MOVE);
    end
  end

  // Selection edges arriving while a move is in progress are discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_idx  <= '0;
      piece_en <= '0;
    end else begin
      if ((state == IDLE) && sel_rise)
        sel_idx <= (sel_idx == SEL_LAST) ? 3'd0 : sel_idx + 3'd1;
      piece_en <= enable ? (NUM_PIECES'(1) << sel_idx) : '0;
    end
  end

  logic [FCW-1:0] frame_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt   <= '0;
      rotate_step <= 1'b0;
    end else begin
      rotate_step <= 1'b0;
      if (frame_start) begin
        if (frame_cnt == FRAME_LAST) begin
          frame_cnt   <= '0;
          rotate_step <= enable && rot;
        end else begin
          frame_cnt <= frame_cnt + FCW'(1);
        end
      end
    end
  end

endmodule
